// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC32 (reflected, LSB-first) over a DATA_W-bit byte-lane word.
// Generate mode appends the 4-byte FCS as a serial byte stream after the frame;
// check mode flags whether frame plus FCS left the expected residue.
module crc32_stream #(
    parameter int          DATA_W    = 8,
    parameter logic [31:0] POLY_REFL = 32'hEDB88320,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE   = 32'hDEBB20E3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    input  logic [$clog2(DATA_W/8):0]     in_bytes,
    output logic [31:0]                   crc_out,
    output logic                          done,
    output logic                          crc_ok,
    output logic                          fcs_valid,
    output logic [7:0]                    fcs_data,
    output logic                          fcs_last
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic {RUN, APPEND} state_t;

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic        pend, pend_next;
    logic        load_fcs;
    logic [31:0] fcs_word;
    logic [31:0] crc_p1;
    logic [31:0] base_p0;
    logic [31:0] fold_p0;
    logic        accept;
    int          n_lanes;

    // One byte through the reflected CRC: 8 LSB-first shift/XOR steps.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == RUN);
    assign fcs_valid = (state == APPEND);
    assign fcs_last  = (state == APPEND) && (cnt == 2'd3);

    // Fold the valid lanes of the current word, lane 0 first; start restarts from INIT.
    always_comb begin
        base_p0 = start ? INIT : crc_p1;
        n_lanes = LANES;
        if (in_last && (in_bytes != '0) && (int'(in_bytes) < LANES)) begin
            n_lanes = int'(in_bytes);
        end
        fold_p0 = base_p0;
        for (int l = 0; l < LANES; l++) begin
            if (l < n_lanes) begin
                fold_p0 = crc_byte(fold_p0, in_data[8*l +: 8]);
            end
        end
    end

    // Next-state logic: RUN enters APPEND the cycle after a generate-mode done.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pend_next  = pend;
        load_fcs   = 1'b0;
        if (accept && in_last && !mode) begin
            pend_next = 1'b1;
        end
        case (state)
            RUN: begin
                if (pend) begin
                    state_next = APPEND;
                    cnt_next   = 2'd0;
                    load_fcs   = 1'b1;
                    pend_next  = accept && in_last && !mode;
                end
            end
            APPEND: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = 2'd0;
                    pend_next  = 1'b0;
                end else if (cnt == 2'd3) begin
                    state_next = RUN;
                    cnt_next   = 2'd0;
                end else begin
                    cnt_next = cnt + 2'd1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // Control state, running CRC register and frame-result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= 2'd0;
            pend    <= 1'b0;
            crc_p1  <= INIT;
            crc_out <= 32'h0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pend  <= pend_next;
            done  <= accept && in_last;
            if (accept) begin
                if (in_last) begin
                    crc_out <= fold_p0 ^ XOROUT;
                    crc_ok  <= mode && (fold_p0 == RESIDUE);
                    crc_p1  <= INIT;
                end else begin
                    crc_p1 <= fold_p0;
                end
            end else if (start) begin
                crc_p1 <= INIT;
            end
        end
    end

    // Snapshot of the FCS so a result landing during APPEND cannot corrupt it.
    always_ff @(posedge clk) begin
        if (load_fcs) begin
            fcs_word <= crc_out;
        end
    end

    // Serialise the FCS least-significant byte first; zero outside APPEND.
    always_comb begin
        fcs_data = 8'h00;
        if (state == APPEND) begin
            case (cnt)
                2'd0:    fcs_data = fcs_word[7:0];
                2'd1:    fcs_data = fcs_word[15:8];
                2'd2:    fcs_data = fcs_word[23:16];
                default: fcs_data = fcs_word[31:24];
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: one 8-bit and one 32-bit instance, table-driven check-mode
// frames plus hand-written sequences for FCS append, abort, start and reset.
module tb_crc32_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic        a_mode, a_start, a_valid, a_ready, a_last, a_done, a_ok, a_fvalid, a_flast;
    logic [7:0]  a_data, a_fdata;
    logic [0:0]  a_bytes;
    logic [31:0] a_crc;

    // 32-bit instance signals
    logic        b_mode, b_start, b_valid, b_ready, b_last, b_done, b_ok, b_fvalid, b_flast;
    logic [31:0] b_data;
    logic [7:0]  b_fdata;
    logic [2:0]  b_bytes;
    logic [31:0] b_crc;

    int n_cmp = 0;
    int n_bad = 0;

    crc32_stream #(.DATA_W(8)) u8 (
        .clk(clk), .rst(rst), .mode(a_mode), .start(a_start), .in_valid(a_valid),
        .in_ready(a_ready), .in_data(a_data), .in_last(a_last), .in_bytes(a_bytes),
        .crc_out(a_crc), .done(a_done), .crc_ok(a_ok), .fcs_valid(a_fvalid),
        .fcs_data(a_fdata), .fcs_last(a_flast)
    );

    crc32_stream #(.DATA_W(32)) u32 (
        .clk(clk), .rst(rst), .mode(b_mode), .start(b_start), .in_valid(b_valid),
        .in_ready(b_ready), .in_data(b_data), .in_last(b_last), .in_bytes(b_bytes),
        .crc_out(b_crc), .done(b_done), .crc_ok(b_ok), .fcs_valid(b_fvalid),
        .fcs_data(b_fdata), .fcs_last(b_flast)
    );

    typedef struct {
        logic         md;
        int           len;
        logic [127:0] d;     // byte i at d[8*i +: 8]
        logic [31:0]  crc;
        logic         ok;
    } vec_t;

    vec_t tv [6];

    // Nibble-table reference CRC (the predecessor's formulation).
    function automatic logic [31:0] nib(input logic [3:0] i);
        case (i)
            4'h0: nib = 32'h00000000;  4'h1: nib = 32'h1DB71064;
            4'h2: nib = 32'h3B6E20C8;  4'h3: nib = 32'h26D930AC;
            4'h4: nib = 32'h76DC4190;  4'h5: nib = 32'h6B6B51F4;
            4'h6: nib = 32'h4DB26158;  4'h7: nib = 32'h5005713C;
            4'h8: nib = 32'hEDB88320;  4'h9: nib = 32'hF00F9344;
            4'hA: nib = 32'hD6D6A3E8;  4'hB: nib = 32'hCB61B38C;
            4'hC: nib = 32'h9B64C2B0;  4'hD: nib = 32'h86D3D2D4;
            4'hE: nib = 32'hA00AE278;  default: nib = 32'hBDBDF21C;
        endcase
    endfunction

    function automatic logic [31:0] model_crc(input logic [127:0] d, input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, d[8*i +: 8]};
            c = (c >> 4) ^ nib(c[3:0]);
            c = (c >> 4) ^ nib(c[3:0]);
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive8(input logic [7:0] b, input logic last, input logic md, input logic st);
        int guard;
        guard = 0;
        a_valid = 1'b1; a_data = b; a_last = last; a_mode = md; a_start = st;
        while (!a_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) chk("ready8_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0; a_start = 1'b0;
    endtask

    task automatic drive32(input logic [31:0] w, input logic last, input logic [2:0] nb,
                           input logic md, input logic st);
        int guard;
        guard = 0;
        b_valid = 1'b1; b_data = w; b_last = last; b_bytes = nb; b_mode = md; b_start = st;
        while (!b_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) chk("ready32_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0; b_start = 1'b0;
    endtask

    task automatic send8(input logic [127:0] d, input int len, input logic md);
        for (int i = 0; i < len; i++) drive8(d[8*i +: 8], (i == len - 1), md, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    localparam logic [127:0] S9  = 128'h39_38373635_34333231;
    localparam logic [127:0] S13 = 128'hCBF43926_39383736_35343332_31;

    initial begin
        logic [7:0]   fexp [4];
        logic [127:0] d;

        rst = 1'b1;
        a_mode = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_data = '0; a_bytes = '0;
        b_mode = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_bytes = '0;

        tv[0] = '{1'b1, 13, S13, 32'h2144DF1C, 1'b1};
        tv[1] = '{1'b1, 13, 128'hCBF43926_39383736_35343332_30,
                  model_crc(128'hCBF43926_39383736_35343332_30, 13), 1'b0};
        tv[2] = '{1'b1, 13, S13, 32'h2144DF1C, 1'b1};
        tv[3] = '{1'b1, 1, 128'h00, 32'hD202EF8D, 1'b0};
        tv[4] = '{1'b1, 1, 128'h61, 32'hE8B7BE43, 1'b0};
        tv[5] = '{1'b1, 9, S9, 32'hCBF43926, 1'b0};

        idle(3);
        rst = 1'b0;
        chk("rst_crc8", a_crc, 32'h0);
        chk("rst_done8", 32'(a_done), 32'd0);
        chk("rst_ready8", 32'(a_ready), 32'd1);
        chk("rst_fvalid8", 32'(a_fvalid), 32'd0);
        chk("rst_crc32", b_crc, 32'h0);

        // Generate mode, "123456789", then the 4-byte FCS
        send8(S9, 9, 1'b0);
        chk("gen_done", 32'(a_done), 32'd1);
        chk("gen_crc", a_crc, 32'hCBF43926);
        chk("gen_ok", 32'(a_ok), 32'd0);
        fexp = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("fcs_valid", 32'(a_fvalid), 32'd1);
            chk("fcs_data", 32'(a_fdata), 32'(fexp[k]));
            chk("fcs_last", 32'(a_flast), (k == 3) ? 32'd1 : 32'd0);
            chk("fcs_ready", 32'(a_ready), 32'd0);
            if (k == 0) chk("done_pulse", 32'(a_done), 32'd0);
        end
        @(posedge clk); #1;
        chk("post_fcs_ready", 32'(a_ready), 32'd1);
        chk("post_fcs_valid", 32'(a_fvalid), 32'd0);

        // Check-mode table, frames back-to-back with no start
        for (int r = 0; r < 6; r++) begin
            send8(tv[r].d, tv[r].len, tv[r].md);
            chk($sformatf("tv%0d_done", r), 32'(a_done), 32'd1);
            chk($sformatf("tv%0d_crc", r), a_crc, tv[r].crc);
            chk($sformatf("tv%0d_ok", r), 32'(a_ok), 32'(tv[r].ok));
            chk($sformatf("tv%0d_noapp", r), 32'(a_fvalid), 32'd0);
        end
        idle(1);
        chk("done_low", 32'(a_done), 32'd0);

        // start together with an accepted word restarts the frame
        drive8(8'hAA, 1'b0, 1'b1, 1'b0);
        drive8(8'hBB, 1'b0, 1'b1, 1'b0);
        drive8(8'h31, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 9; i++) drive8(S9[8*i +: 8], (i == 8), 1'b1, 1'b0);
        chk("start_word_crc", a_crc, 32'hCBF43926);
        drive8(8'h77, 1'b0, 1'b1, 1'b0);
        drive8(8'h61, 1'b1, 1'b1, 1'b1);
        chk("start_single_crc", a_crc, 32'hE8B7BE43);

        // start with no word clears the register, no done pulse
        drive8(8'h55, 1'b0, 1'b1, 1'b0);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("start_only_done", 32'(a_done), 32'd0);
        send8(S9, 9, 1'b1);
        chk("start_only_crc", a_crc, 32'hCBF43926);

        // start on the 2nd FCS byte aborts APPEND
        send8(S9, 9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_byte1", 32'(a_fdata), 32'h39);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("abort_fvalid", 32'(a_fvalid), 32'd0);
        chk("abort_flast", 32'(a_flast), 32'd0);
        chk("abort_ready", 32'(a_ready), 32'd1);
        chk("abort_crc", a_crc, 32'hCBF43926);
        idle(3);
        chk("abort_stays", 32'(a_fvalid), 32'd0);

        // 32-bit lanes: partial final word and padded/oversized in_bytes
        drive32(32'h34333231, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h38373635, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h00000039, 1'b1, 3'd1, 1'b1, 1'b0);
        chk("w32_nb1_crc", b_crc, 32'hCBF43926);
        chk("w32_nb1_done", 32'(b_done), 32'd1);
        d = 128'h00000039_38373635_34333231;
        drive32(32'h34333231, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h38373635, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h00000039, 1'b1, 3'd0, 1'b1, 1'b0);
        chk("w32_nb0_crc", b_crc, model_crc(d, 12));
        drive32(32'h34333231, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h38373635, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h00000039, 1'b1, 3'd5, 1'b1, 1'b0);
        chk("w32_nb5_crc", b_crc, model_crc(d, 12));
        d = 128'h3039_38373635_34333231;
        drive32(32'h34333231, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h38373635, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h00003039, 1'b1, 3'd2, 1'b1, 1'b0);
        chk("w32_nb2_crc", b_crc, model_crc(d, 10));
        drive32(32'h34333231, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h38373635, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'hF4392639, 1'b0, 3'd0, 1'b1, 1'b0);
        drive32(32'h000000CB, 1'b1, 3'd1, 1'b1, 1'b0);
        chk("w32_chk_ok", 32'(b_ok), 32'd1);
        chk("w32_chk_crc", b_crc, 32'h2144DF1C);
        drive32(32'h34333231, 1'b1, 3'd0, 1'b0, 1'b0);
        d = 128'h34333231;
        chk("w32_gen_crc", b_crc, model_crc(d, 4));
        fexp = '{b_crc[7:0], b_crc[15:8], b_crc[23:16], b_crc[31:24]};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("w32_fcs_data", 32'(b_fdata), 32'(fexp[k]));
        end
        idle(1);
        chk("w32_ready_back", 32'(b_ready), 32'd1);

        // rst mid-frame, then a clean frame
        for (int i = 0; i < 5; i++) drive8(S9[8*i +: 8], 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_crc8", a_crc, 32'h0);
        chk("rst2_ok8", 32'(a_ok), 32'd0);
        chk("rst2_done8", 32'(a_done), 32'd0);
        chk("rst2_fvalid8", 32'(a_fvalid), 32'd0);
        chk("rst2_fdata8", 32'(a_fdata), 32'd0);
        chk("rst2_flast8", 32'(a_flast), 32'd0);
        chk("rst2_crc32", b_crc, 32'h0);
        chk("rst2_ok32", 32'(b_ok), 32'd0);
        send8(S9, 9, 1'b0);
        chk("rst2_frame_crc", a_crc, 32'hCBF43926);
        idle(6);
        chk("rst2_ready", 32'(a_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
Parametrised successor to the team's nibble-table Ethernet CRC32 generator. It processes a byte-lane data word per clock, tracks frame boundaries with a valid/ready/last handshake, and handles partial final words. Generate mode appends the 4-byte 802.3 FCS as a serial byte stream; check mode reports whether a received frame plus FCS produced the correct residue. It sits between the MAC byte path and the PHY/RX FIFO in the Ethernet TX and RX chains.

Parameters:
DATA_W, 8, input word width in bits; legal values 8, 16, 32; lane 0 = in_data[7:0] is first on the wire.
POLY_REFL, 32'hEDB88320, reflected CRC polynomial (802.3); data is processed LSB-first.
INIT, 32'hFFFFFFFF, register value at the start of each frame.
XOROUT, 32'hFFFFFFFF, XOR applied to the register to form crc_out and the FCS.
RESIDUE, 32'hDEBB20E3, internal register value (before XOROUT) after a good frame plus FCS.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
mode  in  1  0 = generate/append FCS, 1 = check; sampled on the accepted in_last word.
start  in  1  clears the frame: register <= INIT; aborts APPEND.
in_valid  in  1  in_data/in_last/in_bytes are valid.
in_ready  out  1  block can accept a word.
in_data  in  DATA_W  data word.
in_last  in  1  marks the final word of the frame.
in_bytes  in  clog2(DATA_W/8)+1 (min 1)  number of valid low lanes on the last word; 0 means all lanes; ignored when in_last = 0.
crc_out  out  32  final CRC (register ^ XOROUT) of the last completed frame; held until the next frame completes.
done  out  1  one-cycle pulse when crc_out/crc_ok update.
crc_ok  out  1  check mode: 1 if register == RESIDUE at end of frame; forced to 0 in generate mode.
fcs_valid  out  1  FCS byte on fcs_data is valid.
fcs_data  out  8  FCS byte, least-significant byte of crc_out first.
fcs_last  out  1  asserted with the 4th FCS byte.

Behaviour:
- States: RUN (normal operation) and APPEND (4 cycles, counter 0..3). Reset puts the block in RUN with register = INIT, crc_out = 0, done = 0, crc_ok = 0, fcs_valid = 0, fcs_data = 0, fcs_last = 0, and the append counter = 0.
- in_ready = 1 in RUN and 0 in APPEND. A word is accepted when in_valid && in_ready.
- Accepted non-last word: all DATA_W/8 lanes are folded into the register in lane order, with one-cycle latency. No bubbles are required, so the block sustains one word per clock.
- Accepted last word: only the first N lanes are folded, where N = in_bytes, or all lanes if in_bytes = 0. On the next cycle:
  - crc_out = folded ^ XOROUT;
  - done = 1;
  - crc_ok = (mode == 1 && folded == RESIDUE);
  - the internal register reloads INIT, so back-to-back frames need no start.
- in_bytes greater than DATA_W/8 is treated as all lanes.
- Generate mode: the cycle after done, enter APPEND. Emit crc_out[7:0], [15:8], [23:16], [31:24] on four consecutive cycles with fcs_valid = 1 and fcs_last = 1 on the 4th byte. Return to RUN after the 4th byte; in_ready rises in the cycle following fcs_last.
- Check mode: no APPEND. in_ready stays 1, so the next frame may start the cycle after the last word.
- start in the same cycle as an accepted word: the register is cleared to INIT first, then the word is folded as the first word of the frame. If that word also has in_last, the result is a single-word frame.
- start during APPEND: abort. fcs_valid drops on the next cycle, the state returns to RUN, and crc_out keeps its value.
- start with no valid word: the register becomes INIT and no done pulse is produced.
- rst at any time, including mid-frame or mid-APPEND, restores all reset values on the next edge. No partial FCS byte is emitted after rst.
- The per-byte update is combinational, LSB-first: 8 shift/XOR steps with POLY_REFL per lane, cascaded across lanes. The 32-bit register has no width growth.

Test Plan:
- DATA_W=8, generate mode, bytes "123456789" (31..39 hex) with in_last on 0x39 -> done on the next cycle, crc_out = 32'hCBF43926, then fcs_data 26,39,F4,CB with fcs_last on CB and in_ready = 0 for 4 cycles.
- DATA_W=8, check mode, "123456789" followed by 26 39 F4 CB -> crc_ok = 1. Flip one bit of the payload -> crc_ok = 0.
- DATA_W=32, words 34333231, 38373635, then 39 with in_bytes = 1 -> crc_out = 32'hCBF43926. Repeat with in_bytes = 0 on a padded final word and compare against the golden model.
- Back-to-back check-mode frames with no idle cycle and no start -> each produces an independent correct crc_ok. Mixed good/bad frames -> 1,0,1.
- start asserted on the 2nd FCS byte of APPEND -> fcs_valid = 0 on the next cycle, no fcs_last, in_ready = 1, crc_out unchanged.
- rst mid-frame after 5 bytes, then resend "123456789" -> crc_out = 32'hCBF43926. Also check that all outputs are 0 in the cycle after rst.
